smu_dbus_fabric: RTL and testbench
==================================

// Module: smu_dbus_fabric
// PURPOSE
//  Parametrised data-bus fabric between riscv core data port and NUM_SLV slaves (DMEM, TBMAN, GPIO, UART, timer).
//  Decodes address against per-slave base/mask, drives one active-low chip select, waits for slave ack.
//  Returns registered read data, ready and bus-error to the master. Unmapped addresses and slave timeouts
//  raise m_err instead of hanging the core.
// PARAMETERS
//  NUM_SLV    4                 number of slave ports (1..8)
//  AWIDTH     32                address width
//  DWIDTH     32                data width; byte enables are DWIDTH/8
//  SLV_BASE   {NUM_SLV*AWIDTH}  packed base addresses, slave i at [i*AWIDTH +: AWIDTH]
//  SLV_MASK   {NUM_SLV*AWIDTH}  packed match masks; hit_i = ((addr & mask_i) == base_i)
//  TIMEOUT    15                ACCESS cycles without ack before error; 0 disables timeout
// PORTS
//  clk       in   1                clock
//  n_rst     in   1                asynchronous active-low reset
//  m_req     in   1                master request, sampled in IDLE only
//  m_we      in   1                1 = write, 0 = read
//  m_addr    in   AWIDTH           byte address
//  m_wdata   in   DWIDTH           write data
//  m_be      in   DWIDTH/8         byte enables
//  m_rdata   out  DWIDTH           read data, valid with m_ready
//  m_ready   out  1                one-cycle completion pulse
//  m_err     out  1                bus error, qualifies m_ready
//  s_cs_n    out  NUM_SLV          per-slave chip select, active low
//  s_we      out  1                shared write strobe (latched m_we)
//  s_addr    out  AWIDTH           shared latched address
//  s_wdata   out  DWIDTH           shared latched write data
//  s_be      out  DWIDTH/8         shared latched byte enables
//  s_rdata   in   NUM_SLV*DWIDTH   packed slave read data
//  s_ack     in   NUM_SLV          per-slave ack
// BEHAVIOUR
//  Reset: state=IDLE, s_cs_n all 1, m_ready=0, m_err=0, m_rdata=0, latched regs=0, timeout counter=0.
//  FSM IDLE -> ACCESS | ERR; ACCESS -> DONE; ERR -> IDLE; DONE -> IDLE.
//  IDLE: on m_req, latch we/addr/wdata/be and one-hot select (lowest index wins on overlap).
//    no hit -> ERR; hit -> ACCESS.
//  ACCESS: s_cs_n[sel]=0, others 1. s_we/s_addr/s_wdata/s_be driven from latches, stable whole access.
//    counter increments each ACCESS cycle.
//    s_ack[sel]=1 -> capture s_rdata[sel] into m_rdata (0 on write), go DONE.
//      Ack from a non-selected slave is ignored.
//    counter==TIMEOUT-1 and no ack (TIMEOUT>0) -> m_rdata=0, set err flag, go DONE.
//    Ack on the timeout cycle wins: normal completion.
//  DONE: m_ready=1 for exactly one cycle; m_err=err flag. s_cs_n all 1. Counter cleared.
//  ERR: m_ready=1, m_err=1, m_rdata=0 for one cycle; no chip select asserted.
//  Latency: zero-wait slave (ack in first ACCESS cycle) -> m_ready 2 cycles after the req-sampling edge.
//    Each slave wait cycle adds 1.
//  m_req outside IDLE is ignored; no queuing. Back-to-back requests issue every 3 cycles minimum.
//  Master holds m_req high until m_ready to re-issue; fabric re-samples only in IDLE.
//  n_rst assertion mid-access: immediate return to reset values; the slave sees cs_n rise asynchronously.
// STRUCTURE
//  smu_dbus_pkg: state enum (IDLE, ACCESS, DONE, ERR) as localparams; default memory-map constants
//    DMEM 0x1000_0000/0xFFFF_C000, TBMAN 0x8000_0000/0xFFFF_0000.
//  Sub-module smu_dbus_decoder: combinational addr -> one-hot hit[NUM_SLV] + any_hit, lowest-index priority.
//  Top holds FSM, latches, timeout counter, registered read mux.
// TESTING
//  Read DMEM 0x1000_0010, slave acks at once with 0xDEADBEEF -> cs_n[0] low 1 cycle, m_ready+rdata=0xDEADBEEF 2 cycles after req.
//  Write TBMAN 0x8000_0004, be=4'b0011, ack after 3 waits -> s_be=0011 held 4 cycles, m_ready at cycle 5, m_err=0.
//  Read unmapped 0x4000_0000 -> no cs_n low, m_ready=1 m_err=1 m_rdata=0 the cycle after req.
//  Slave never acks, TIMEOUT=15 -> cs_n low exactly 15 cycles, then m_ready=1 m_err=1.
//  s_ack[1] pulsed while slave 0 selected -> ignored; completion only on s_ack[0].
//  n_rst low during ACCESS -> s_cs_n all 1, m_ready=0 at once; next req after release completes normally.

Source files
------------

// File: rtl/smu_dbus_pkg.sv
// Shared types and default memory map for the core data-bus fabric.
// Default slave order: DMEM, TBMAN, GPIO, UART.
package smu_dbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE,
        ST_ERR
    } dbus_state_e;

    localparam logic [31:0] DMEM_BASE  = 32'h1000_0000;
    localparam logic [31:0] DMEM_MASK  = 32'hFFFF_C000;
    localparam logic [31:0] TBMAN_BASE = 32'h8000_0000;
    localparam logic [31:0] TBMAN_MASK = 32'hFFFF_0000;
    localparam logic [31:0] GPIO_BASE  = 32'hC000_0000;
    localparam logic [31:0] GPIO_MASK  = 32'hFFFF_F000;
    localparam logic [31:0] UART_BASE  = 32'hC000_1000;
    localparam logic [31:0] UART_MASK  = 32'hFFFF_F000;

    localparam logic [127:0] DEF_SLV_BASE = {UART_BASE, GPIO_BASE, TBMAN_BASE, DMEM_BASE};
    localparam logic [127:0] DEF_SLV_MASK = {UART_MASK, GPIO_MASK, TBMAN_MASK, DMEM_MASK};

endpackage

// File: rtl/smu_dbus_decoder.sv
// Combinational address decoder: one-hot slave hit, lowest index wins on overlapping windows.
module smu_dbus_decoder #(
    parameter int unsigned NUM_SLV = 4,
    parameter int unsigned AWIDTH  = 32,
    parameter logic [NUM_SLV*AWIDTH-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLV*AWIDTH-1:0] SLV_MASK = '0
) (
    input  logic [AWIDTH-1:0]  addr,
    output logic [NUM_SLV-1:0] hit,
    output logic               any_hit
);

    logic found;

    always_comb begin
        hit   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (!found && ((addr & SLV_MASK[i*AWIDTH +: AWIDTH]) == SLV_BASE[i*AWIDTH +: AWIDTH])) begin
                hit[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    assign any_hit = found;

endmodule

// File: rtl/smu_dbus_fabric.sv
// Data-bus fabric between the core data port and NUM_SLV slaves: decode, chip select,
// ack wait with timeout, registered read-data return and bus-error reporting.
module smu_dbus_fabric
    import smu_dbus_pkg::*;
#(
    parameter int unsigned NUM_SLV = 4,
    parameter int unsigned AWIDTH  = 32,
    parameter int unsigned DWIDTH  = 32,
    parameter logic [NUM_SLV*AWIDTH-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [NUM_SLV*AWIDTH-1:0] SLV_MASK = DEF_SLV_MASK,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      m_req,
    input  logic                      m_we,
    input  logic [AWIDTH-1:0]         m_addr,
    input  logic [DWIDTH-1:0]         m_wdata,
    input  logic [DWIDTH/8-1:0]       m_be,
    output logic [DWIDTH-1:0]         m_rdata,
    output logic                      m_ready,
    output logic                      m_err,
    output logic [NUM_SLV-1:0]        s_cs_n,
    output logic                      s_we,
    output logic [AWIDTH-1:0]         s_addr,
    output logic [DWIDTH-1:0]         s_wdata,
    output logic [DWIDTH/8-1:0]       s_be,
    input  logic [NUM_SLV*DWIDTH-1:0] s_rdata,
    input  logic [NUM_SLV-1:0]        s_ack
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    dbus_state_e state, state_nxt;

    logic [NUM_SLV-1:0]  hit;
    logic                any_hit;
    logic [NUM_SLV-1:0]  sel_q;
    logic                we_q;
    logic [AWIDTH-1:0]   addr_q;
    logic [DWIDTH-1:0]   wdata_q;
    logic [DWIDTH/8-1:0] be_q;
    logic [DWIDTH-1:0]   rdata_q;
    logic                err_q;
    logic [CW-1:0]       tcnt;
    logic [DWIDTH-1:0]   rd_mux;
    logic                ack_sel;
    logic                timeout;

    smu_dbus_decoder #(
        .NUM_SLV  (NUM_SLV),
        .AWIDTH   (AWIDTH),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decoder (
        .addr    (m_addr),
        .hit     (hit),
        .any_hit (any_hit)
    );

    // Only the latched selection can complete an access; stray acks are masked here.
    assign ack_sel = |(s_ack & sel_q);
    assign timeout = (TIMEOUT > 0) && (tcnt == TO_LAST);

    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (sel_q[i]) begin
                rd_mux = rd_mux | s_rdata[i*DWIDTH +: DWIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (m_req) state_nxt = any_hit ? ST_ACCESS : ST_ERR;
            ST_ACCESS: if (ack_sel || timeout) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            ST_ERR:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        m_ready = (state == ST_DONE) || (state == ST_ERR);
        m_err   = (state == ST_ERR) || ((state == ST_DONE) && err_q);
        s_cs_n  = (state == ST_ACCESS) ? ~sel_q : '1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tcnt    <= '0;
        end else begin
            tcnt <= (state == ST_ACCESS) ? tcnt + CW'(1) : '0;
            case (state)
                ST_IDLE: begin
                    if (m_req) begin
                        sel_q   <= hit;
                        we_q    <= m_we;
                        addr_q  <= m_addr;
                        wdata_q <= m_wdata;
                        be_q    <= m_be;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (ack_sel) begin
                        rdata_q <= we_q ? '0 : rd_mux;
                        err_q   <= 1'b0;
                    end else if (timeout) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_rdata = rdata_q;
    assign s_we    = we_q;
    assign s_addr  = addr_q;
    assign s_wdata = wdata_q;
    assign s_be    = be_q;

endmodule

// File: tb/tb_smu_dbus_fabric.sv
// Self-checking bench for smu_dbus_fabric with a behavioural slave responder and a result scoreboard.
module tb_smu_dbus_fabric;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        m_req = 1'b0;
    logic        m_we = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_be = '0;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        m_err;
    logic [3:0]  s_cs_n;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_be;
    logic [127:0] s_rdata;
    logic [3:0]  s_ack;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int total = 0;
    int bad   = 0;

    int unsigned wait_c[4];
    int unsigned lowcnt[4];
    logic [31:0] srd[4];
    logic [3:0]  ack_en = 4'hF;
    logic [3:0]  ack_m = '0;
    logic        stray_en = 1'b0;

    always #5 clk = ~clk;

    smu_dbus_fabric #(.NUM_SLV(4), .AWIDTH(32), .DWIDTH(32), .TIMEOUT(15)) dut (
        .clk(clk), .n_rst(n_rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_be(m_be), .m_rdata(m_rdata), .m_ready(m_ready),
        .m_err(m_err), .s_cs_n(s_cs_n), .s_we(s_we), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_be(s_be), .s_rdata(s_rdata), .s_ack(s_ack)
    );

    assign s_rdata = {srd[3], srd[2], srd[1], srd[0]};
    assign s_ack   = ack_m | {2'b00, stray_en & ~s_cs_n[0], 1'b0};

    // Slave i acks after wait_c[i] cycles of its chip select being low.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!s_cs_n[i]) begin
                ack_m[i] = ack_en[i] && (lowcnt[i] == wait_c[i]);
                lowcnt[i]++;
            end else begin
                ack_m[i]  = 1'b0;
                lowcnt[i] = 0;
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output int lat, output int cslo,
                         output logic [3:0] csmask, output logic [31:0] rd,
                         output logic er, output logic stable);
        logic done = 1'b0;
        lat = 0; cslo = 0; csmask = '0; rd = 'x; er = 'x; stable = 1'b1;
        @(posedge clk); #1;
        m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata; m_be = be;
        @(posedge clk); #1;
        m_req = 1'b0; m_we = ~we; m_addr = ~addr; m_wdata = ~wdata; m_be = ~be;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (s_cs_n != 4'hF) begin
                cslo++;
                csmask = csmask | ~s_cs_n;
                if (s_be !== be || s_addr !== addr || s_we !== we || s_wdata !== wdata) stable = 1'b0;
            end
            if (m_ready === 1'b1) begin
                done = 1'b1; rd = m_rdata; er = m_err;
            end
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (s_cs_n !== 4'hF) begin bad++; $display("FAIL reset_cs_n: got %h want f", s_cs_n); end
        total++; if (m_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", m_ready); end
        total++; if (m_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", m_err); end
        total++; if (m_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", m_rdata); end
        total++; if (s_addr !== 32'h0 || s_be !== 4'h0 || s_we !== 1'b0) begin
            bad++; $display("FAIL reset_latches: got addr=%h be=%h we=%b want 0", s_addr, s_be, s_we); end
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_read_dmem();
        int lat, cslo; logic [3:0] msk; logic [31:0] rd; logic er, st;
        wait_c[0] = 0; srd[0] = 32'hDEAD_BEEF;
        sb.push_back('{32'hDEAD_BEEF, 1'b0});
        issue(1'b0, 32'h1000_0010, 32'h0, 4'hF, lat, cslo, msk, rd, er, st);
        e = sb.pop_front();
        total++; if (lat != 2) begin bad++; $display("FAIL read_latency: got %0d want 2", lat); end
        total++; if (cslo != 1 || msk !== 4'b0001) begin bad++; $display("FAIL read_cs: got %0d cycles mask %b want 1 0001", cslo, msk); end
        total++; if (rd !== e.data || er !== e.err) begin bad++; $display("FAIL read_data: got %h/%b want %h/%b", rd, er, e.data, e.err); end
        @(negedge clk);
        total++; if (m_ready !== 1'b0) begin bad++; $display("FAIL read_ready_pulse: got %b want 0", m_ready); end
    endtask

    task automatic test_unmapped();
        int lat, cslo; logic [3:0] msk; logic [31:0] rd; logic er, st;
        sb.push_back('{32'h0, 1'b1});
        issue(1'b0, 32'h4000_0000, 32'h0, 4'hF, lat, cslo, msk, rd, er, st);
        e = sb.pop_front();
        total++; if (lat != 1) begin bad++; $display("FAIL unmapped_latency: got %0d want 1", lat); end
        total++; if (cslo != 0) begin bad++; $display("FAIL unmapped_cs: got %0d cycles want 0", cslo); end
        total++; if (rd !== e.data || er !== e.err) begin bad++; $display("FAIL unmapped_resp: got %h/%b want %h/%b", rd, er, e.data, e.err); end
    endtask

    task automatic test_write_tbman();
        int lat, cslo; logic [3:0] msk; logic [31:0] rd; logic er, st;
        wait_c[1] = 3; srd[1] = 32'hA5A5_A5A5;
        sb.push_back('{32'h0, 1'b0});
        issue(1'b1, 32'h8000_0004, 32'hCAFE_0001, 4'b0011, lat, cslo, msk, rd, er, st);
        e = sb.pop_front();
        total++; if (lat != 5) begin bad++; $display("FAIL write_latency: got %0d want 5", lat); end
        total++; if (cslo != 4 || msk !== 4'b0010) begin bad++; $display("FAIL write_cs: got %0d cycles mask %b want 4 0010", cslo, msk); end
        total++; if (st !== 1'b1) begin bad++; $display("FAIL write_stable: got %b want 1", st); end
        total++; if (rd !== e.data || er !== e.err) begin bad++; $display("FAIL write_resp: got %h/%b want %h/%b", rd, er, e.data, e.err); end
    endtask

    task automatic test_timeout();
        int lat, cslo; logic [3:0] msk; logic [31:0] rd; logic er, st;
        ack_en[2] = 1'b0; srd[2] = 32'h7777_7777;
        sb.push_back('{32'h0, 1'b1});
        issue(1'b0, 32'hC000_0004, 32'h0, 4'hF, lat, cslo, msk, rd, er, st);
        e = sb.pop_front();
        total++; if (lat != 16) begin bad++; $display("FAIL timeout_latency: got %0d want 16", lat); end
        total++; if (cslo != 15 || msk !== 4'b0100) begin bad++; $display("FAIL timeout_cs: got %0d cycles mask %b want 15 0100", cslo, msk); end
        total++; if (rd !== e.data || er !== e.err) begin bad++; $display("FAIL timeout_resp: got %h/%b want %h/%b", rd, er, e.data, e.err); end
        ack_en[2] = 1'b1;
    endtask

    task automatic test_stray_ack();
        int lat, cslo; logic [3:0] msk; logic [31:0] rd; logic er, st;
        wait_c[0] = 4; srd[0] = 32'h1234_5678; srd[1] = 32'hFFFF_0000; stray_en = 1'b1;
        sb.push_back('{32'h1234_5678, 1'b0});
        issue(1'b0, 32'h1000_0100, 32'h0, 4'hF, lat, cslo, msk, rd, er, st);
        e = sb.pop_front();
        stray_en = 1'b0;
        total++; if (lat != 6) begin bad++; $display("FAIL stray_latency: got %0d want 6", lat); end
        total++; if (cslo != 5 || msk !== 4'b0001) begin bad++; $display("FAIL stray_cs: got %0d cycles mask %b want 5 0001", cslo, msk); end
        total++; if (rd !== e.data || er !== e.err) begin bad++; $display("FAIL stray_resp: got %h/%b want %h/%b", rd, er, e.data, e.err); end
    endtask

    task automatic test_reset_mid_access();
        int lat, cslo; logic [3:0] msk; logic [31:0] rd; logic er, st;
        ack_en[0] = 1'b0;
        @(posedge clk); #1;
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h1000_0040; m_be = 4'hF;
        @(posedge clk); #1;
        m_req = 1'b0;
        @(negedge clk); @(negedge clk);
        total++; if (s_cs_n !== 4'b1110) begin bad++; $display("FAIL midrst_pre_cs: got %b want 1110", s_cs_n); end
        #2 n_rst = 1'b0;
        #1;
        total++; if (s_cs_n !== 4'hF) begin bad++; $display("FAIL midrst_cs: got %b want 1111", s_cs_n); end
        total++; if (m_ready !== 1'b0 || m_err !== 1'b0 || s_addr !== 32'h0) begin
            bad++; $display("FAIL midrst_outputs: got ready=%b err=%b addr=%h want 0", m_ready, m_err, s_addr); end
        @(posedge clk); #1;
        n_rst = 1'b1; ack_en[0] = 1'b1; wait_c[0] = 1; srd[0] = 32'h5555_AAAA;
        sb.push_back('{32'h5555_AAAA, 1'b0});
        issue(1'b0, 32'h1000_0040, 32'h0, 4'hF, lat, cslo, msk, rd, er, st);
        e = sb.pop_front();
        total++; if (lat != 3) begin bad++; $display("FAIL midrst_after_latency: got %0d want 3", lat); end
        total++; if (rd !== e.data || er !== e.err) begin bad++; $display("FAIL midrst_after_resp: got %h/%b want %h/%b", rd, er, e.data, e.err); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int last = 0;
        wait_c[0] = 0; srd[0] = 32'h0BAD_F00D;
        for (int k = 0; k < 4; k++) sb.push_back('{32'h0BAD_F00D, 1'b0});
        @(posedge clk); #1;
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h1000_0020; m_be = 4'hF;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (m_ready === 1'b1) begin
                pulses++;
                total++; if (c - last != ((last == 0) ? 2 : 3)) begin
                    bad++; $display("FAIL b2b_spacing: got %0d want %0d", c - last, (last == 0) ? 2 : 3); end
                last = c;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    total++; if (m_rdata !== e.data || m_err !== e.err) begin
                        bad++; $display("FAIL b2b_resp: got %h/%b want %h/%b", m_rdata, m_err, e.data, e.err); end
                end
            end
        end
        m_req = 1'b0;
        total++; if (pulses != 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", pulses); end
        sb.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            wait_c[i] = 0; lowcnt[i] = 0; srd[i] = 32'h0;
        end
        test_reset();
        test_read_dmem();
        test_unmapped();
        test_write_tbman();
        test_timeout();
        test_stray_ack();
        test_reset_mid_access();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
